// File: rtl/gauss_sample_collector_if.sv
// Sample-collector bus: post-process input stream, valid/ready output, status and counters.
// The DUT side is the slave modport; the producer/consumer side is the master modport.
interface gauss_sample_collector_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              samp_valid;
    logic [DATA_W-1:0] samp_data;
    logic              flush;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic [15:0]       drop_cnt;
    logic [31:0]       acc_cnt;
    logic [31:0]       rej_cnt;

    modport master (
        output samp_valid, samp_data, flush, m_ready,
        input  m_valid, m_data, full, empty, level, drop_cnt, acc_cnt, rej_cnt
    );

    modport slave (
        input  samp_valid, samp_data, flush, m_ready,
        output m_valid, m_data, full, empty, level, drop_cnt, acc_cnt, rej_cnt
    );
endinterface

// File: rtl/gauss_sample_collector.sv
// Buffers accepted (non-zero) Gaussian samples in a FIFO, discards rejects, counts overflow drops.
// Define GAUSS_STATS_EN to build the acceptance/rejection counters; otherwise they read 0.
module gauss_sample_collector #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic                     clk,
    input logic                     rst,
    gauss_sample_collector_if.slave bus
);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W:0]   level, level_nxt;
    logic              full_q, full_nxt;
    logic              empty_q, empty_nxt;
    logic [15:0]       drop_cnt, drop_cnt_nxt;

    logic acc;
    logic pop;
    logic push;
    logic drop;

    // A genuine zero sample is indistinguishable from a reject and is dropped as one.
    assign acc  = bus.samp_valid && (bus.samp_data != '0);
    assign pop  = !empty_q && bus.m_ready;
    assign push = acc && (!full_q || pop) && !bus.flush;
    assign drop = acc && full_q && !pop && !bus.flush;

    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        rd_ptr_nxt   = rd_ptr;
        wr_ptr_nxt   = wr_ptr;
        level_nxt    = level;
        drop_cnt_nxt = drop_cnt;

        if (bus.flush) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            level_nxt  = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
            unique case ({push, pop})
                2'b10:   level_nxt = level + LVL_ONE;
                2'b01:   level_nxt = level - LVL_ONE;
                default: level_nxt = level;
            endcase
            if (drop && (drop_cnt != 16'hFFFF)) drop_cnt_nxt = drop_cnt + 16'd1;
        end

        full_nxt  = (level_nxt == LVL_FULL);
        empty_nxt = (level_nxt == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            drop_cnt <= '0;
        end else begin
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            level    <= level_nxt;
            full_q   <= full_nxt;
            empty_q  <= empty_nxt;
            drop_cnt <= drop_cnt_nxt;
        end
    end

    // NOTE: storage is deliberately not reset; it is never observed while empty, and
    // leaving reset off lets it map onto plain RAM/flop arrays without reset muxes.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= bus.samp_data;
    end

    assign bus.m_valid  = !empty_q;
    assign bus.m_data   = empty_q ? '0 : mem[rd_ptr];
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.level    = level;
    assign bus.drop_cnt = drop_cnt;

`ifdef GAUSS_STATS_EN
    logic        rej;
    logic [31:0] acc_cnt;
    logic [31:0] rej_cnt;

    assign rej = bus.samp_valid && (bus.samp_data == '0);

    // Counts every qualified sample, including drops and flush-cycle arrivals; wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt <= '0;
            rej_cnt <= '0;
        end else begin
            if (acc) acc_cnt <= acc_cnt + 32'd1;
            if (rej) rej_cnt <= rej_cnt + 32'd1;
        end
    end

    assign bus.acc_cnt = acc_cnt;
    assign bus.rej_cnt = rej_cnt;
`else
    assign bus.acc_cnt = '0;
    assign bus.rej_cnt = '0;
`endif
endmodule

// File: tb/tb_gauss_sample_collector.sv
// Directed bench for gauss_sample_collector: reset, mixed stream, overflow, full push/pop,
// back-pressure, flush and mid-operation reset.
module tb_gauss_sample_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gauss_sample_collector_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    gauss_sample_collector #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [4:0]  exp_level;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then land just after the rising edge.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
        @(negedge clk);
        bus.samp_valid = v;
        bus.samp_data  = d;
        bus.m_ready    = r;
        bus.flush      = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        mix [5];
        logic        rdy [6];
        logic [31:0] bp_head [6];
        logic [4:0]  bp_lvl [6];

        bus.samp_valid = 1'b0;
        bus.samp_data  = '0;
        bus.m_ready    = 1'b0;
        bus.flush      = 1'b0;

        // 1. reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_drop", 32'(bus.drop_cnt), 32'd0);
        check("rst_m_data", bus.m_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 2. mixed accept/reject stream with consumer always ready
        mix[0] = '{1'b1, 32'h0001_2345, 1'b1, 1'b1, 32'h0001_2345, 5'd1};
        mix[1] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 5'd0};
        mix[2] = '{1'b1, 32'hFFFE_0000, 1'b1, 1'b1, 32'hFFFE_0000, 5'd1};
        mix[3] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 5'd0};
        mix[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 5'd0};
        for (int i = 0; i < 5; i++) begin
            step(mix[i].v, mix[i].d, mix[i].r, 1'b0);
            check($sformatf("mix%0d_valid", i), 32'(bus.m_valid), 32'(mix[i].exp_valid));
            check($sformatf("mix%0d_data", i), bus.m_data, mix[i].exp_data);
            check($sformatf("mix%0d_level", i), 32'(bus.level), 32'(mix[i].exp_level));
        end
`ifdef GAUSS_STATS_EN
        check("mix_acc_cnt", bus.acc_cnt, 32'd2);
        check("mix_rej_cnt", bus.rej_cnt, 32'd2);
`else
        check("mix_acc_cnt", bus.acc_cnt, 32'd0);
        check("mix_rej_cnt", bus.rej_cnt, 32'd0);
`endif

        // 3. fill past capacity with no consumer, then drain
        for (int i = 1; i <= 18; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0);
            check($sformatf("fill%0d_level", i), 32'(bus.level), (i > 16) ? 32'd16 : 32'(i));
            check($sformatf("fill%0d_drop", i), 32'(bus.drop_cnt), (i > 16) ? 32'(i - 16) : 32'd0);
        end
        check("fill_full", 32'(bus.full), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("drain%0d_valid", k), 32'(bus.m_valid), 32'd1);
            check($sformatf("drain%0d_data", k), bus.m_data, 32'(k));
            step(1'b0, 32'd0, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        check("drain_level", 32'(bus.level), 32'd0);

        // 4. full FIFO with simultaneous push and pop
        for (int i = 1; i <= 16; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0);
        check("pp_full_before", 32'(bus.full), 32'd1);
        check("pp_head_before", bus.m_data, 32'd101);
        step(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0);
        check("pp_level", 32'(bus.level), 32'd16);
        check("pp_full", 32'(bus.full), 32'd1);
        check("pp_drop", 32'(bus.drop_cnt), 32'd2);
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("pp_drain%0d", k), bus.m_data,
                  (k < 16) ? 32'(101 + k) : 32'hA5A5_A5A5);
            step(1'b0, 32'd0, 1'b1, 1'b0);
        end
        check("pp_empty", 32'(bus.empty), 32'd1);

        // 5. back-pressure with a toggling ready
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b0);
        check("bp_level_start", 32'(bus.level), 32'd3);
        rdy     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bp_head = '{32'h11, 32'h11, 32'h11, 32'h22, 32'h22, 32'h33};
        bp_lvl  = '{5'd3, 5'd3, 5'd2, 5'd2, 5'd1, 5'd0};
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp%0d_head", i), bus.m_data, bp_head[i]);
            step(1'b0, 32'd0, rdy[i], 1'b0);
            check($sformatf("bp%0d_level", i), 32'(bus.level), 32'(bp_lvl[i]));
        end

        // 6a. flush with five entries and an accepted sample in the flush cycle
        for (int i = 1; i <= 5; i++) step(1'b1, 32'(32'h200 + i), 1'b0, 1'b0);
        check("fl_level_before", 32'(bus.level), 32'd5);
        step(1'b1, 32'h77, 1'b0, 1'b1);
        check("fl_level", 32'(bus.level), 32'd0);
        check("fl_empty", 32'(bus.empty), 32'd1);
        check("fl_valid", 32'(bus.m_valid), 32'd0);
        check("fl_drop", 32'(bus.drop_cnt), 32'd2);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("fl_lost_level", 32'(bus.level), 32'd0);
        check("fl_lost_data", bus.m_data, 32'd0);

        // 6b. reset with seven entries buffered
        for (int i = 1; i <= 7; i++) step(1'b1, 32'(32'h300 + i), 1'b0, 1'b0);
        check("rs_level_before", 32'(bus.level), 32'd7);
        @(negedge clk);
        rst            = 1'b1;
        bus.samp_valid = 1'b1;
        bus.samp_data  = 32'h99;
        @(posedge clk);
        #1;
        check("rs_level", 32'(bus.level), 32'd0);
        check("rs_valid", 32'(bus.m_valid), 32'd0);
        check("rs_empty", 32'(bus.empty), 32'd1);
        check("rs_full", 32'(bus.full), 32'd0);
        check("rs_drop", 32'(bus.drop_cnt), 32'd0);
        check("rs_data", bus.m_data, 32'd0);
        check("rs_acc_cnt", bus.acc_cnt, 32'd0);
        check("rs_rej_cnt", bus.rej_cnt, 32'd0);
        @(negedge clk);
        rst            = 1'b0;
        bus.samp_valid = 1'b0;
        bus.samp_data  = '0;
        bus.m_ready    = 1'b1;
        @(posedge clk);
        #1;
        check("rs_after_valid", 32'(bus.m_valid), 32'd0);
        check("rs_after_level", 32'(bus.level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
